// File: rtl/alarm_stream_pkg.sv
// alarm_stream_pkg: shared state enum, default widths and FIFO entry type for the alarm ROM streamer
package alarm_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} stream_state_t;
  localparam int ALARM_ADDR_W = 15;
  localparam int ALARM_DATA_W = 32;
  localparam int ALARM_MEM_WORDS = 20480;
  typedef struct packed {
    logic [ALARM_DATA_W-1:0] data;
    logic last;
  } fifo_entry_t;
endpackage

// File: rtl/alarm_stream_fifo.sv
// alarm_stream_fifo: synchronous first-word-fall-through FIFO with clear and occupancy
module alarm_stream_fifo
  import alarm_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fifo_entry_t              wdata,
  output fifo_entry_t              rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic pop_ok;
  assign valid = occupancy != '0;
  assign pop_ok = pop && valid;
  assign rdata = valid ? mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr <= '0;
      rptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) rptr <= rptr + AW'(1);
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/alarm_rom_streamer.sv
// alarm_rom_streamer: credit-managed ROM block reader to valid/ready stream; looping passes built only with ALARM_STREAMER_LOOP_EN
module alarm_rom_streamer
  import alarm_stream_pkg::*;
#(
  parameter int ADDR_W     = ALARM_ADDR_W,
  parameter int DATA_W     = ALARM_DATA_W,
  parameter int MEM_WORDS  = ALARM_MEM_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  stream_state_t state, state_next;
  logic [ADDR_W-1:0] base, addr, next_addr;
  logic [CNT_W-1:0] total, remain;
  logic [OW-1:0] occ;
  logic outstanding, out_last, zero_done, pop, credit, issue, final_issue, loop_en, drained, accept;
  fifo_entry_t wentry, rentry;
`ifdef ALARM_STREAMER_LOOP_EN
  logic loop_q;
  always_ff @(posedge clk) loop_q <= reset ? 1'b0 : accept ? loop : loop_q;
  assign loop_en = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en = 1'b0;
`endif
  assign accept = state == IDLE && start;
  assign pop = st_valid && st_ready;
  assign credit = int'(occ) + int'(outstanding) - int'(pop) < FIFO_DEPTH;
  assign issue = state == RUN && !stop && remain != '0 && credit;
  assign final_issue = issue && remain == CNT_W'(1);
  assign drained = !outstanding && occ == OW'(pop);
  assign next_addr = addr == ADDR_W'(MEM_WORDS - 1) ? '0 : addr + ADDR_W'(1);
  assign mem_chipselect = issue;
  assign mem_address = addr;
  assign busy = state != IDLE;
  assign done = zero_done || (state == DRAIN && drained && !stop) || state == FLUSH;
  assign wentry = '{data: mem_readdata, last: out_last};
  assign st_data = rentry.data;
  assign st_last = rentry.last;
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = stop && state != IDLE ? FLUSH :
                 state == IDLE  ? (accept && word_count != '0 ? RUN : IDLE) :
                 state == RUN   ? (final_issue && !loop_en ? DRAIN : RUN) :
                 state == DRAIN ? (drained ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      addr <= '0;
      total <= '0;
      remain <= '0;
      outstanding <= 1'b0;
      out_last <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= accept && word_count == '0;
      outstanding <= issue;
      out_last <= final_issue;
      if (accept) begin
        base <= start_addr;
        addr <= start_addr;
        total <= word_count;
        remain <= word_count;
      end else if (issue) begin
        addr <= final_issue && loop_en ? base : next_addr;
        remain <= final_issue && loop_en ? total : remain - CNT_W'(1);
      end
    end
  end
  alarm_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(outstanding),
    .pop(pop),
    .clear(stop && state != IDLE),
    .wdata(wentry),
    .rdata(rentry),
    .valid(st_valid),
    .occupancy(occ)
  );
endmodule
